// File: rtl/cram_port_arbiter_if.sv
// Bundles the engine, CPU, host and RAM signals of the cart RAM arbiter.
// Combinational wiring only; no latency.
// The bus has no backpressure: engine writes queue or drop, the CPU reads the latest request, host_req waits for host_ack.
interface cram_port_arbiter_if #(
  parameter int AW         = 17,
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          eng_wr;
  logic [AW-1:0] eng_addr;
  logic [7:0]    eng_do;

  logic          cpu_rd;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_do;
  logic          cpu_valid;
  logic          cpu_busy;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata;
  logic          host_ack;
  logic [7:0]    host_rdata;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;

  logic [LW-1:0] fifo_level;
  logic          eng_ovf;

  // Arbiter side
  modport slave (
    input  eng_wr, eng_addr, eng_do,
    input  cpu_rd, cpu_addr,
    output cpu_do, cpu_valid, cpu_busy,
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata,
    output fifo_level, eng_ovf
  );

  // Requester / RAM side
  modport master (
    output eng_wr, eng_addr, eng_do,
    output cpu_rd, cpu_addr,
    input  cpu_do, cpu_valid, cpu_busy,
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata,
    input  fifo_level, eng_ovf
  );
endinterface

// File: rtl/cram_port_arbiter.sv
// Shares one single-port cart RAM between the engine write FIFO, CPU reads and the host save port.
// An op granted in cycle N drives the RAM in N+1; its read data and cpu_valid/host_ack appear in N+2.
// No stall signals: a full FIFO drops the write (sticky eng_ovf), a CPU read waits in a slot, host_req is held until ack.
module cram_port_arbiter #(
  parameter int AW          = 17,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOST_STARVE = 8
) (
  input  logic              clk_sys,
  input  logic              reset,
  cram_port_arbiter_if.slave bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int SW = $clog2(HOST_STARVE + 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    wdat;
  } eng_ent_t;

  typedef enum logic [1:0] {TAG_NONE, TAG_CPU, TAG_HOST_RD, TAG_HOST_WR} tag_e;
  typedef enum logic [1:0] {H_IDLE, H_BUSY, H_WAIT} host_st_e;
  typedef enum logic [1:0] {G_NONE, G_HOST, G_ENG, G_CPU} grant_e;

  eng_ent_t      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] fifo_cnt;
  logic          fifo_empty;
  logic          fifo_full;
  logic          eng_push;
  logic          eng_pop;
  eng_ent_t      fifo_head;
  logic          eng_ovf_q;

  logic          cpu_pend;
  logic [AW-1:0] cpu_pend_addr;

  host_st_e      host_st;
  host_st_e      host_nx;
  logic          host_elig;
  logic          host_done;
  logic [SW-1:0] starve_cnt;
  logic          starved;

  grant_e        grant;

  logic [AW-1:0] ram_addr_q;
  logic          ram_we_q;
  logic [7:0]    ram_wdata_q;
  tag_e          tag_q1;
  tag_e          tag_q2;
  logic [7:0]    cpu_do_q;
  logic [7:0]    host_rdata_q;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == LW'(FIFO_DEPTH));
  assign fifo_head  = fifo_mem[rd_ptr];
  assign eng_pop    = (grant == G_ENG);
  // A full FIFO still accepts a write in a cycle where the head is popped.
  assign eng_push   = bus.eng_wr && (!fifo_full || eng_pop);

  assign host_elig  = (host_st == H_IDLE) && bus.host_req;
  assign starved    = (starve_cnt == SW'(HOST_STARVE));
  assign host_done  = (tag_q2 == TAG_HOST_RD) || (tag_q2 == TAG_HOST_WR);

  // Pick at most one RAM user per cycle; a starved host jumps ahead of the engine.
  always_comb begin
    grant = G_NONE;
    if (host_elig && starved) begin
      grant = G_HOST;
    end else if (!fifo_empty) begin
      grant = G_ENG;
    end else if (cpu_pend) begin
      grant = G_CPU;
    end else if (host_elig) begin
      grant = G_HOST;
    end
  end

  // Engine FIFO storage; entries need no reset because the pointers define validity.
  always_ff @(posedge clk_sys) begin
    if (eng_push) begin
      fifo_mem[wr_ptr] <= '{addr: bus.eng_addr, wdat: bus.eng_do};
    end
  end

  // Engine FIFO pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      eng_ovf_q <= 1'b0;
    end else begin
      if (eng_push) wr_ptr <= wr_ptr + PW'(1);
      if (eng_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({eng_push, eng_pop})
        2'b10:   fifo_cnt <= fifo_cnt + LW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - LW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (bus.eng_wr && fifo_full && !eng_pop) eng_ovf_q <= 1'b1;
    end
  end

  // CPU pending slot: newest request wins, a request arriving on the issue cycle stays pending.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cpu_pend      <= 1'b0;
      cpu_pend_addr <= '0;
    end else if (bus.cpu_rd) begin
      cpu_pend      <= 1'b1;
      cpu_pend_addr <= bus.cpu_addr;
    end else if (grant == G_CPU) begin
      cpu_pend      <= 1'b0;
    end
  end

  // Count non-host grants the waiting host has suffered, saturating at the limit.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!bus.host_req || grant == G_HOST) begin
      starve_cnt <= '0;
    end else if (host_elig && (grant == G_ENG || grant == G_CPU) && !starved) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Host request state register.
  always_ff @(posedge clk_sys) begin
    if (reset) host_st <= H_IDLE;
    else       host_st <= host_nx;
  end

  // Host request next state: one grant per request, then wait for host_req to drop.
  always_comb begin
    host_nx = host_st;
    case (host_st)
      H_IDLE:  if (grant == G_HOST) host_nx = H_BUSY;
      H_BUSY:  if (host_done)       host_nx = H_WAIT;
      H_WAIT:  if (!bus.host_req)   host_nx = H_IDLE;
      default: host_nx = H_IDLE;
    endcase
  end

  // Register the RAM port and carry the owner tag alongside the read pipeline.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      tag_q1      <= TAG_NONE;
      tag_q2      <= TAG_NONE;
    end else begin
      tag_q2   <= tag_q1;
      tag_q1   <= TAG_NONE;
      ram_we_q <= 1'b0;
      case (grant)
        G_ENG: begin
          ram_addr_q  <= fifo_head.addr;
          ram_wdata_q <= fifo_head.wdat;
          ram_we_q    <= 1'b1;
        end
        G_CPU: begin
          ram_addr_q <= cpu_pend_addr;
          tag_q1     <= TAG_CPU;
        end
        G_HOST: begin
          ram_addr_q  <= bus.host_addr;
          ram_wdata_q <= bus.host_wdata;
          ram_we_q    <= bus.host_we;
          tag_q1      <= bus.host_we ? TAG_HOST_WR : TAG_HOST_RD;
        end
        default: ;
      endcase
    end
  end

  // Hold the last returned data for each owner once its completion cycle has passed.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cpu_do_q     <= '0;
      host_rdata_q <= '0;
    end else begin
      if (tag_q2 == TAG_CPU)     cpu_do_q     <= bus.ram_rdata;
      if (tag_q2 == TAG_HOST_RD) host_rdata_q <= bus.ram_rdata;
    end
  end

  // Read data is forwarded straight from the RAM in the completion cycle, held afterwards.
  assign bus.cpu_valid  = (tag_q2 == TAG_CPU);
  assign bus.cpu_do     = (tag_q2 == TAG_CPU) ? bus.ram_rdata : cpu_do_q;
  assign bus.cpu_busy   = cpu_pend || (tag_q1 == TAG_CPU);
  assign bus.host_ack   = host_done;
  assign bus.host_rdata = (tag_q2 == TAG_HOST_RD) ? bus.ram_rdata : host_rdata_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.fifo_level = fifo_cnt;
  assign bus.eng_ovf    = eng_ovf_q;

endmodule

// File: tb/tb_cram_port_arbiter.sv
// Directed bench for cram_port_arbiter with a 1-cycle-latency RAM model.
// Inputs change on the falling edge, outputs are checked on the falling edge.
// Engine traffic can be left streaming in the background to stress the host and CPU paths.
module tb_cram_port_arbiter;
  localparam int AW = 17;

  logic clk_sys;
  logic reset;
  int   n_checks;
  int   n_errors;
  bit   eng_stream;
  int   eng_ptr;
  int   peak;
  int   nv;
  int   nr20;
  int   nack;
  logic [7:0] last_do;
  logic [7:0] ram_mem [0:(1<<AW)-1];

  cram_port_arbiter_if #(.AW(AW), .FIFO_DEPTH(4)) bus ();

  cram_port_arbiter #(.AW(AW), .FIFO_DEPTH(4), .HOST_STARVE(8)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Single-port RAM, read-first, one cycle read latency.
  always @(posedge clk_sys) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= ram_mem[bus.ram_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {15'd0, bus.cpu_do, bus.cpu_valid, bus.cpu_busy, bus.host_ack, bus.host_rdata,
            bus.ram_addr, bus.ram_we, bus.ram_wdata, bus.fifo_level, bus.eng_ovf};
  endfunction

  // Advance one clock; background engine stream writes 0x100+n with data n.
  task automatic tick();
    if (eng_stream) begin
      bus.eng_wr   = 1'b1;
      bus.eng_addr = AW'(32'h100 + eng_ptr);
      bus.eng_do   = 8'(eng_ptr);
      eng_ptr++;
    end
    @(negedge clk_sys);
  endtask

  task automatic host_op(input string tag, input logic we, input logic [AW-1:0] addr,
                         input logic [7:0] wd, input logic [7:0] exp_rd,
                         input int exp_eng, input logic hold_extra);
    int  n_eng;
    bit  found;
    int  acks;
    bus.host_req   = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = addr;
    bus.host_wdata = wd;
    n_eng = 0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick();
      if (bus.ram_addr == addr && bus.ram_we == we) found = 1'b1;
      else if (bus.ram_we) n_eng++;
    end
    chk({tag, "_granted"}, 64'(found), 64'(1));
    chk({tag, "_eng_grants_before"}, 64'(n_eng), 64'(exp_eng));
    tick();
    chk({tag, "_ack"}, 64'(bus.host_ack), 64'(1));
    if (!we) chk({tag, "_rdata"}, 64'(bus.host_rdata), 64'(exp_rd));
    if (!hold_extra) bus.host_req = 1'b0;
    tick();
    chk({tag, "_ack_single"}, 64'(bus.host_ack), 64'(0));
    bus.host_req = 1'b0;
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      acks += int'(bus.host_ack);
    end
    chk({tag, "_no_regrant"}, 64'(acks), 64'(0));
    if (!we) chk({tag, "_rdata_held"}, 64'(bus.host_rdata), 64'(exp_rd));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    eng_stream = 1'b0;
    eng_ptr = 0;
    reset = 1'b1;
    bus.eng_wr = 1'b0;  bus.eng_addr = '0;  bus.eng_do = '0;
    bus.cpu_rd = 1'b0;  bus.cpu_addr = '0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;

    // Reset state
    @(negedge clk_sys);
    tick();
    tick();
    chk("reset_outputs", all_outs(), 64'd0);
    reset = 1'b0;
    tick();
    chk("idle_after_reset", all_outs(), 64'd0);

    // Four back-to-back engine writes land in order on consecutive cycles
    peak = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        bus.eng_wr   = 1'b1;
        bus.eng_addr = AW'(32'h10 + i);
        bus.eng_do   = 8'(32'hA0 + i);
      end else begin
        bus.eng_wr = 1'b0;
      end
      tick();
      if (int'(bus.fifo_level) > peak) peak = int'(bus.fifo_level);
      if (i >= 1 && i <= 4) begin
        chk("burst4_we", 64'(bus.ram_we), 64'(1));
        chk("burst4_addr", 64'(bus.ram_addr), 64'(32'h10 + i - 1));
        chk("burst4_wdata", 64'(bus.ram_wdata), 64'(32'hA0 + i - 1));
      end
      if (i == 5) begin
        chk("burst4_idle_we", 64'(bus.ram_we), 64'(0));
        chk("burst4_idle_addr_hold", 64'(bus.ram_addr), 64'(32'h13));
      end
    end
    chk("burst4_peak_le2", 64'(peak <= 2), 64'(1));
    chk("burst4_no_ovf", 64'(bus.eng_ovf), 64'(0));

    // 8-cycle engine burst starves a pending CPU read until the FIFO drains
    for (int i = 0; i < 12; i++) begin
      if (i < 8) begin
        bus.eng_wr   = 1'b1;
        bus.eng_addr = AW'(32'h30 + i);
        bus.eng_do   = 8'(32'hB0 + i);
      end else begin
        bus.eng_wr = 1'b0;
      end
      bus.cpu_rd   = (i == 0);
      bus.cpu_addr = AW'(32'h12);
      tick();
      if (i + 1 >= 2 && i + 1 <= 9) begin
        chk("burst8_we", 64'(bus.ram_we), 64'(1));
        chk("burst8_addr", 64'(bus.ram_addr), 64'(32'h30 + i - 1));
        chk("burst8_cpu_wait", 64'(bus.cpu_valid), 64'(0));
      end
      if (i + 1 == 5) chk("burst8_cpu_busy", 64'(bus.cpu_busy), 64'(1));
      if (i + 1 == 10) begin
        chk("cpurd_port_addr", 64'(bus.ram_addr), 64'(32'h12));
        chk("cpurd_port_we", 64'(bus.ram_we), 64'(0));
        chk("cpurd_not_early", 64'(bus.cpu_valid), 64'(0));
      end
      if (i + 1 == 11) begin
        chk("cpurd_valid", 64'(bus.cpu_valid), 64'(1));
        chk("cpurd_data", 64'(bus.cpu_do), 64'(8'hA2));
      end
      if (i + 1 == 12) begin
        chk("cpurd_valid_pulse", 64'(bus.cpu_valid), 64'(0));
        chk("cpurd_data_held", 64'(bus.cpu_do), 64'(8'hA2));
        chk("cpurd_busy_clear", 64'(bus.cpu_busy), 64'(0));
      end
    end
    chk("burst8_no_ovf", 64'(bus.eng_ovf), 64'(0));

    // Host writes on an idle RAM; the first keeps host_req high past its ack
    host_op("hwr55", 1'b1, AW'(32'h55), 8'h3C, 8'h00, 0, 1'b1);
    host_op("hwr20", 1'b1, AW'(32'h20), 8'h5A, 8'h00, 0, 1'b0);
    host_op("hwr21", 1'b1, AW'(32'h21), 8'h6B, 8'h00, 0, 1'b0);

    // Two CPU reads while the FIFO is busy: only the second address is read
    nv = 0;
    nr20 = 0;
    last_do = 8'h00;
    eng_stream = 1'b1;
    bus.cpu_rd = 1'b1;
    bus.cpu_addr = AW'(32'h20);
    for (int k = 0; k < 16; k++) begin
      if (k == 1) bus.cpu_addr = AW'(32'h21);
      if (k == 2) bus.cpu_rd = 1'b0;
      if (k == 5) begin
        eng_stream = 1'b0;
        bus.eng_wr = 1'b0;
      end
      tick();
      if (bus.cpu_valid) begin
        nv++;
        last_do = bus.cpu_do;
      end
      if (!bus.ram_we && bus.ram_addr == AW'(32'h20)) nr20++;
    end
    chk("latest_wins_valid_count", 64'(nv), 64'(1));
    chk("latest_wins_data", 64'(last_do), 64'(8'h6B));
    chk("latest_wins_no_old_read", 64'(nr20), 64'(0));

    // Host reads under continuous engine traffic: each waits exactly 8 engine grants,
    // and each stolen slot raises the FIFO level by one until a write is dropped
    eng_stream = 1'b1;
    tick();
    host_op("hrd_starve1", 1'b0, AW'(32'h55), 8'h00, 8'h3C, 8, 1'b0);
    chk("level_after_h1", 64'(bus.fifo_level), 64'(2));
    host_op("hrd_starve2", 1'b0, AW'(32'h20), 8'h00, 8'h5A, 8, 1'b0);
    chk("level_after_h2", 64'(bus.fifo_level), 64'(3));
    host_op("hrd_starve3", 1'b0, AW'(32'h21), 8'h00, 8'h6B, 8, 1'b0);
    chk("level_after_h3", 64'(bus.fifo_level), 64'(4));
    chk("no_ovf_at_full", 64'(bus.eng_ovf), 64'(0));
    host_op("hrd_starve4", 1'b0, AW'(32'h55), 8'h00, 8'h3C, 8, 1'b0);
    chk("level_after_h4", 64'(bus.fifo_level), 64'(4));
    chk("ovf_set", 64'(bus.eng_ovf), 64'(1));
    eng_stream = 1'b0;
    bus.eng_wr = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    chk("fifo_drained", 64'(bus.fifo_level), 64'(0));
    chk("ovf_sticky", 64'(bus.eng_ovf), 64'(1));

    // Reset in the middle of a host read abandons it
    bus.host_req = 1'b1;
    bus.host_we = 1'b0;
    bus.host_addr = AW'(32'h55);
    tick();
    chk("midrst_port_addr", 64'(bus.ram_addr), 64'(32'h55));
    reset = 1'b1;
    tick();
    chk("midrst_outputs_zero", all_outs(), 64'd0);
    reset = 1'b0;
    bus.host_req = 1'b0;
    nack = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      nack += int'(bus.host_ack) + int'(bus.cpu_valid);
    end
    chk("midrst_no_ack", 64'(nack), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
